uart_rx_sampler_mv: RTL and testbench

UART_RX_SAMPLER_MV -- requirements
Module: uart_rx_sampler_mv

---
 rtl/uart_rx_sampler_mv.sv | 136 +++++++++++++
 tb/tb_uart_rx_sampler_mv.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_sampler_mv.sv
// Majority-vote bit sampler for a UART receiver: optional RX_IN synchroniser,
// a 1/3/5-vote window centred on Prescale/2, and a registered decision strobe.
module uart_rx_sampler_mv #(
  parameter int WIDTH       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             RX_IN,
  input  logic [WIDTH-1:0] Prescale,
  input  logic [2:0]       samp_num,
  input  logic             dat_samp_en,
  input  logic [WIDTH-1:0] edge_cnt,
  output logic             sampled_bit,
  output logic             sample_valid,
  output logic             noise_err
);

  localparam int XW = WIDTH + 1;

  logic rx_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign rx_s = RX_IN;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_r;

      // Synchroniser chain, preset to the idle-high line level.
      always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
          sync_r <= '1;
        end else begin
          sync_r[0] <= RX_IN;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
          end
        end
      end

      assign rx_s = sync_r[SYNC_STAGES-1];
    end
  endgenerate

  logic [2:0]    n_eff_s;
  logic [2:0]    half_s;
  logic [XW-1:0] mid_s;
  logic [XW-1:0] lo_s;
  logic [XW-1:0] hi_s;
  logic [XW-1:0] dec_s;
  logic [XW-1:0] edge_x_s;
  logic          in_win_s;
  logic          at_dec_s;

  // Window geometry, all in WIDTH+1 bits so dec cannot wrap to zero.
  always_comb begin
    case (samp_num)
      3'd1:    n_eff_s = 3'd1;
      3'd3:    n_eff_s = 3'd3;
      3'd5:    n_eff_s = 3'd5;
      default: n_eff_s = 3'd3;
    endcase
    half_s   = (n_eff_s - 3'd1) >> 1;
    mid_s    = {1'b0, Prescale} >> 1;
    lo_s     = mid_s - XW'(half_s);
    hi_s     = mid_s + XW'(half_s);
    dec_s    = hi_s + XW'(1);
    edge_x_s = {1'b0, edge_cnt};
    in_win_s = (edge_x_s >= lo_s) && (edge_x_s <= hi_s);
    at_dec_s = (edge_x_s == dec_s);
  end

  logic [2:0] ones_r;
  logic [2:0] votes_r;
  logic       hold_r;
  logic [2:0] ones_nxt_s;
  logic [2:0] votes_nxt_s;
  logic       hold_nxt_s;
  logic       bit_nxt_s;
  logic       nerr_nxt_s;
  logic       valid_nxt_s;

  // Vote accumulation and the decision, with a hold flag so a parked dec fires once.
  always_comb begin
    ones_nxt_s  = ones_r;
    votes_nxt_s = votes_r;
    hold_nxt_s  = hold_r;
    bit_nxt_s   = sampled_bit;
    nerr_nxt_s  = noise_err;
    valid_nxt_s = 1'b0;
    if (!dat_samp_en) begin
      ones_nxt_s  = 3'd0;
      votes_nxt_s = 3'd0;
      hold_nxt_s  = 1'b0;
    end else if (at_dec_s) begin
      ones_nxt_s  = 3'd0;
      votes_nxt_s = 3'd0;
      if (!hold_r) begin
        bit_nxt_s   = ({ones_r, 1'b0} > {1'b0, n_eff_s});
        nerr_nxt_s  = ((ones_r != 3'd0) && (ones_r != n_eff_s)) || (votes_r != n_eff_s);
        valid_nxt_s = 1'b1;
        hold_nxt_s  = 1'b1;
      end else begin
        hold_nxt_s  = 1'b1;
      end
    end else if (in_win_s) begin
      ones_nxt_s  = (ones_r == 3'd7) ? ones_r : ones_r + {2'b00, rx_s};
      votes_nxt_s = (votes_r == 3'd7) ? votes_r : votes_r + 3'd1;
      hold_nxt_s  = 1'b0;
    end else begin
      ones_nxt_s  = 3'd0;
      votes_nxt_s = 3'd0;
      hold_nxt_s  = 1'b0;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      ones_r       <= 3'd0;
      votes_r      <= 3'd0;
      hold_r       <= 1'b0;
      sampled_bit  <= 1'b0;
      noise_err    <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      ones_r       <= ones_nxt_s;
      votes_r      <= votes_nxt_s;
      hold_r       <= hold_nxt_s;
      sampled_bit  <= bit_nxt_s;
      noise_err    <= nerr_nxt_s;
      sample_valid <= valid_nxt_s;
    end
  end

endmodule

// File: tb/tb_uart_rx_sampler_mv.sv
// Directed bench for uart_rx_sampler_mv: one instance without synchroniser,
// one with two stages, both driven by the same stimulus.
module tb_uart_rx_sampler_mv;

  logic       clk;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic [2:0] samp_num;
  logic       dat_samp_en;
  logic [5:0] edge_cnt;
  logic       sb0, sv0, ne0;
  logic       sb2, sv2, ne2;

  int tests;
  int fails;
  int pulses0;
  int pulses2;
  int p_edge0;
  logic p_bit0, p_ne0;
  logic p_bit2, p_ne2;

  uart_rx_sampler_mv #(.WIDTH(6), .SYNC_STAGES(0)) dut0 (
    .clk(clk), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .samp_num(samp_num),
    .dat_samp_en(dat_samp_en), .edge_cnt(edge_cnt),
    .sampled_bit(sb0), .sample_valid(sv0), .noise_err(ne0)
  );

  uart_rx_sampler_mv #(.WIDTH(6), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .samp_num(samp_num),
    .dat_samp_en(dat_samp_en), .edge_cnt(edge_cnt),
    .sampled_bit(sb2), .sample_valid(sv2), .noise_err(ne2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int e, input logic rx);
    edge_cnt = 6'(e);
    RX_IN    = rx;
    @(posedge clk);
    #1;
    if (sv0) begin
      pulses0++;
      p_edge0 = e;
      p_bit0  = sb0;
      p_ne0   = ne0;
    end
    if (sv2) begin
      pulses2++;
      p_bit2 = sb2;
      p_ne2  = ne2;
    end
  endtask

  task automatic clr_pulses();
    pulses0 = 0;
    pulses2 = 0;
    p_edge0 = -1;
    p_bit0  = 1'bx;
    p_ne0   = 1'bx;
    p_bit2  = 1'bx;
    p_ne2   = 1'bx;
  endtask

  task automatic run_bit(input int n, input logic [31:0] mask);
    clr_pulses();
    for (int e = 0; e < n; e++) begin
      cyc(e, mask[e]);
    end
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    RST         = 1'b0;
    RX_IN       = 1'b1;
    dat_samp_en = 1'b0;
    edge_cnt    = 6'd0;
    Prescale    = 6'd8;
    samp_num    = 3'd3;
    clr_pulses();

    #12;
    chk("rst_bit", 32'(sb0), 32'd0);
    chk("rst_valid", 32'(sv0), 32'd0);
    chk("rst_noise", 32'(ne0), 32'd0);
    chk("rst_sync", 32'(dut2.g_sync.sync_r), 32'h3);
    @(posedge clk);
    #1;
    RST         = 1'b1;
    dat_samp_en = 1'b1;

    // P=8, n=3, window 3..5, dec 6; votes 1,1,0
    run_bit(8, 32'hFFFF_FFDF);
    chk("p8n3_pulses", 32'(pulses0), 32'd1);
    chk("p8n3_edge", 32'(p_edge0), 32'd6);
    chk("p8n3_bit", 32'(p_bit0), 32'd1);
    chk("p8n3_noise", 32'(p_ne0), 32'd1);
    chk("p8n3_after", 32'(sv0), 32'd0);

    // samp_num=4 falls back to 3 votes
    samp_num = 3'd4;
    run_bit(8, 32'hFFFF_FFDF);
    chk("n4_edge", 32'(p_edge0), 32'd6);
    chk("n4_bit", 32'(p_bit0), 32'd1);
    chk("n4_noise", 32'(p_ne0), 32'd1);

    // P=16, n=5, window 6..10, dec 11; high only at 7 and 9
    Prescale = 6'd16;
    samp_num = 3'd5;
    run_bit(16, 32'h0000_0280);
    chk("p16n5_pulses", 32'(pulses0), 32'd1);
    chk("p16n5_edge", 32'(p_edge0), 32'd11);
    chk("p16n5_bit", 32'(p_bit0), 32'd0);
    chk("p16n5_noise", 32'(p_ne0), 32'd1);

    // P=32, n=1, window 16..16, dec 17
    Prescale = 6'd32;
    samp_num = 3'd1;
    run_bit(32, 32'h0001_0000);
    chk("p32n1_edge", 32'(p_edge0), 32'd17);
    chk("p32n1_bit", 32'(p_bit0), 32'd1);
    chk("p32n1_noise", 32'(p_ne0), 32'd0);

    // P=8, n=5, window 2..6, dec 7; clean zero line
    Prescale = 6'd8;
    samp_num = 3'd5;
    run_bit(8, 32'h0000_0000);
    chk("p8n5_edge", 32'(p_edge0), 32'd7);
    chk("p8n5_bit", 32'(p_bit0), 32'd0);
    chk("p8n5_noise", 32'(p_ne0), 32'd0);

    // edge_cnt parked on dec gives a single pulse; leaving and returning fires again
    samp_num = 3'd3;
    clr_pulses();
    cyc(3, 1'b1);
    cyc(4, 1'b1);
    cyc(5, 1'b1);
    cyc(6, 1'b1);
    cyc(6, 1'b1);
    cyc(6, 1'b1);
    chk("hold_pulses", 32'(pulses0), 32'd1);
    chk("hold_bit", 32'(sb0), 32'd1);
    chk("hold_noise", 32'(ne0), 32'd0);
    cyc(7, 1'b1);
    cyc(6, 1'b1);
    chk("redec_pulses", 32'(pulses0), 32'd2);
    chk("redec_bit", 32'(sb0), 32'd0);
    chk("redec_noise", 32'(ne0), 32'd1);

    // Window entered late: two votes, both high
    clr_pulses();
    cyc(4, 1'b1);
    cyc(5, 1'b1);
    cyc(6, 1'b0);
    chk("late_pulses", 32'(pulses0), 32'd1);
    chk("late_bit", 32'(p_bit0), 32'd1);
    chk("late_noise", 32'(p_ne0), 32'd1);

    // Two-stage synchroniser: flush low, step high at edge_cnt=1
    dat_samp_en = 1'b0;
    cyc(0, 1'b0);
    cyc(0, 1'b0);
    cyc(0, 1'b0);
    dat_samp_en = 1'b1;
    clr_pulses();
    cyc(0, 1'b0);
    cyc(1, 1'b1);
    chk("sync_lag1", 32'(dut2.rx_s), 32'd0);
    cyc(2, 1'b1);
    chk("sync_lag2", 32'(dut2.rx_s), 32'd1);
    for (int e = 3; e < 8; e++) begin
      cyc(e, 1'b1);
    end
    chk("sync_pulses", 32'(pulses2), 32'd1);
    chk("sync_bit", 32'(p_bit2), 32'd1);
    chk("sync_noise", 32'(p_ne2), 32'd0);

    // Step one cycle later: first vote still sees the old low level
    dat_samp_en = 1'b0;
    cyc(0, 1'b0);
    cyc(0, 1'b0);
    cyc(0, 1'b0);
    dat_samp_en = 1'b1;
    run_bit(8, 32'hFFFF_FFFC);
    chk("sync_late_bit", 32'(p_bit2), 32'd1);
    chk("sync_late_noise", 32'(p_ne2), 32'd1);

    // Clean all-ones bit, then drop dat_samp_en mid-window
    run_bit(8, 32'hFFFF_FFFF);
    chk("pre_drop_bit", 32'(sb0), 32'd1);
    clr_pulses();
    for (int e = 0; e < 4; e++) begin
      cyc(e, 1'b0);
    end
    dat_samp_en = 1'b0;
    for (int e = 4; e < 8; e++) begin
      cyc(e, 1'b0);
    end
    chk("drop_pulses", 32'(pulses0), 32'd0);
    chk("drop_bit_held", 32'(sb0), 32'd1);
    chk("drop_noise_held", 32'(ne0), 32'd0);

    // Reset asserted at edge_cnt=4, released there, partial window follows
    dat_samp_en = 1'b1;
    for (int e = 0; e < 4; e++) begin
      cyc(e, 1'b0);
    end
    edge_cnt = 6'd4;
    #2;
    RST = 1'b0;
    #1;
    chk("rst4_bit", 32'(sb0), 32'd0);
    chk("rst4_valid", 32'(sv0), 32'd0);
    chk("rst4_noise", 32'(ne0), 32'd0);
    chk("rst4_sync", 32'(dut2.g_sync.sync_r), 32'h3);
    @(posedge clk);
    #1;
    RST = 1'b1;
    clr_pulses();
    cyc(5, 1'b1);
    chk("rst4_nodec", 32'(sv0), 32'd0);
    cyc(6, 1'b1);
    chk("rst4_valid_dec", 32'(sv0), 32'd1);
    chk("rst4_bit_dec", 32'(sb0), 32'd0);
    chk("rst4_noise_dec", 32'(ne0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
